// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed combinationally from latched operands; only the latency is modelled.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  op_e              dec_op, op_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      opa, opb;
  logic             accept, is_muldiv, div_zero;
  logic             unused_instr_bits;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, safe_b, safe_ub;
  logic [31:0] q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;

  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    dec_op = OP_NONE;
    if (instr[31:26] == 6'h00) begin
      case (instr[5:0])
        6'h18:   dec_op = OP_MULT;
        6'h19:   dec_op = OP_MULTU;
        6'h1A:   dec_op = OP_DIV;
        6'h1B:   dec_op = OP_DIVU;
        6'h11:   dec_op = OP_MTHI;
        6'h13:   dec_op = OP_MTLO;
        default: dec_op = OP_NONE;
      endcase
    end
  end

  assign is_muldiv = (dec_op == OP_MULT) || (dec_op == OP_MULTU) ||
                     (dec_op == OP_DIV)  || (dec_op == OP_DIVU);
  assign busy      = (cnt != '0);
  assign accept    = start && !busy && (dec_op != OP_NONE);
  assign div_zero  = (opb == 32'd0);

  // Signed division goes through magnitudes so that 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s  = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
    prod_u  = {32'd0, opa} * {32'd0, opb};
    abs_a   = opa[31] ? -opa : opa;
    abs_b   = opb[31] ? -opb : opb;
    safe_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    q_mag   = abs_a / safe_b;
    r_mag   = abs_a % safe_b;
    quot_s  = (opa[31] ^ opb[31]) ? -q_mag : q_mag;
    rem_s   = opa[31] ? -r_mag : r_mag;
    safe_ub = div_zero ? 32'd1 : opb;
    quot_u  = opa / safe_ub;
    rem_u   = opa % safe_ub;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_muldiv) state_d = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hi      <= 32'd0;
      lo      <= 32'd0;
      cnt     <= '0;
      opa     <= 32'd0;
      opb     <= 32'd0;
      op_q    <= OP_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        case (dec_op)
          OP_MTHI: hi <= rs;
          OP_MTLO: lo <= rs;
          OP_MULT, OP_MULTU: begin
            opa  <= rs;
            opb  <= rt;
            op_q <= dec_op;
            cnt  <= CNT_W'(MULT_CYCLES);
          end
          OP_DIV, OP_DIVU: begin
            opa  <= rs;
            opb  <= rt;
            op_q <= dec_op;
            cnt  <= CNT_W'(DIV_CYCLES);
          end
          default: ;
        endcase
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
        // HI/LO change only on the final countdown edge; a zero divisor leaves them alone.
        if (cnt == CNT_W'(1)) begin
          case (op_q)
            OP_MULT:  {hi, lo} <= prod_s;
            OP_MULTU: {hi, lo} <= prod_u;
            OP_DIV: begin
              if (!div_zero) begin
                lo <= quot_s;
                hi <= rem_s;
              end
            end
            OP_DIVU: begin
              if (!div_zero) begin
                lo <= quot_u;
                hi <= rem_u;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares whenever busy drops.
module tb_mult_div_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, rs, rt;
  logic        start;
  logic [31:0] hi, lo;
  logic        busy;

  typedef struct {
    string       name;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   prev_busy = 1'b0;
  int   run_len = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .instr (instr),
    .rs    (rs),
    .rt    (rt),
    .start (start),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] funct);
    return {6'h00, 20'h00000, funct};
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int len, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.name = name;
    e.len  = len;
    e.hi   = h;
    e.lo   = l;
    sb.push_back(e);
  endtask

  // Drives a one-edge start pulse beginning at the current time.
  task automatic applyStimulus(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    instr = enc(funct);
    rs    = a;
    rt    = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] h, input logic [31:0] l, input logic bz);
    compare({name, "_hi"}, hi, h);
    compare({name, "_lo"}, lo, l);
    compare({name, "_busy"}, {31'd0, busy}, {31'd0, bz});
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: busy ran %0d cycles with no expected result", run_len);
        end else begin
          exp_t e;
          e = sb.pop_front();
          compare({e.name, "_len"}, run_len, e.len);
          compare({e.name, "_hi"}, hi, e.hi);
          compare({e.name, "_lo"}, lo, e.lo);
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    instr = 32'd0;
    rs    = 32'd0;
    rt    = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("reset", 32'd0, 32'd0, 1'b0);
    mon_en = 1'b1;

    @(posedge clk); #1;
    push("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    applyStimulus(F_MULT, 32'hFFFFFFFE, 32'd3);
    waitIdle("mult");

    @(posedge clk); #1;
    push("multu", 5, 32'h00000002, 32'hFFFFFFFA);
    applyStimulus(F_MULTU, 32'hFFFFFFFE, 32'd3);
    waitIdle("multu");

    @(posedge clk); #1;
    push("div", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    applyStimulus(F_DIV, 32'hFFFFFFF9, 32'd2);
    waitIdle("div");

    @(posedge clk); #1;
    push("divu", 10, 32'd1, 32'd3);
    applyStimulus(F_DIVU, 32'd7, 32'd2);
    waitIdle("divu");

    @(posedge clk); #1;
    applyStimulus(F_MTHI, 32'h1234, 32'd0);
    applyStimulus(F_MTLO, 32'h5678, 32'd0);
    @(negedge clk);
    checkOutput("mthi_mtlo", 32'h1234, 32'h5678, 1'b0);

    @(posedge clk); #1;
    applyStimulus(F_MTHI, 32'hAAAA, 32'd0);
    @(negedge clk);
    checkOutput("mthi_only", 32'hAAAA, 32'h5678, 1'b0);
    @(posedge clk); #1;
    applyStimulus(F_MTLO, 32'hBBBB, 32'd0);
    @(negedge clk);
    checkOutput("mtlo_only", 32'hAAAA, 32'hBBBB, 1'b0);

    @(posedge clk); #1;
    push("div_zero", 10, 32'hAAAA, 32'hBBBB);
    applyStimulus(F_DIV, 32'h55, 32'd0);
    waitIdle("div_zero");

    @(posedge clk); #1;
    push("div_ovf", 10, 32'd0, 32'h80000000);
    applyStimulus(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitIdle("div_ovf");

    @(posedge clk); #1;
    push("mult_6x7", 5, 32'd0, 32'h2A);
    applyStimulus(F_MULT, 32'd6, 32'd7);
    @(posedge clk); #1;
    applyStimulus(F_DIV, 32'd100, 32'd3);
    waitIdle("mult_6x7");

    @(posedge clk); #1;
    applyStimulus(F_ADD, 32'h111, 32'h222);
    repeat (2) @(negedge clk);
    checkOutput("add_ignored", 32'd0, 32'h2A, 1'b0);

    @(posedge clk); #1;
    push("mult_reset", 3, 32'd0, 32'd0);
    applyStimulus(F_MULT, 32'd3, 32'd5);
    @(negedge clk);
    checkOutput("hold_busy", 32'd0, 32'h2A, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_midflight", 32'd0, 32'd0, 1'b0);

    @(posedge clk); #1;
    push("b2b_first", 5, 32'd0, 32'h14);
    applyStimulus(F_MULT, 32'd4, 32'd5);
    waitIdle("b2b_first");
    push("b2b_second", 5, 32'd0, 32'h20);
    applyStimulus(F_MULT, 32'h10, 32'd2);
    rs = 32'hDEAD;
    rt = 32'hBEEF;
    waitIdle("b2b_second");

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
